// File: rtl/pipeline_trace_monitor_if.sv
// Trace drain handshake between the monitor (producer) and a host/bench (consumer).
interface pipeline_trace_monitor_if;
    logic        trc_valid;
    logic        trc_ready;
    logic [63:0] trc_data;

    modport master (output trc_valid, output trc_data, input  trc_ready);
    modport slave  (input  trc_valid, input  trc_data, output trc_ready);
endinterface

// File: rtl/pipeline_trace_monitor.sv
// Passive CPU debug observer: statistics counters plus a show-ahead FIFO of
// accepted fetches {PC, instruction}, drained over a valid/ready handshake.
module pipeline_trace_monitor #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     mon_en,
    input  logic                     clr,
    input  logic [31:0]              PC,
    input  logic [1:0]               pcsource,
    input  logic [31:0]              if_inst,
    input  logic                     stall,
    input  logic [1:0]               FwdA,
    input  logic [1:0]               FwdB,
    pipeline_trace_monitor_if.master trc,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         xfer_cnt,
    output logic [CNT_W-1:0]         fwd_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 64;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic [DW-1:0]    r_data;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [DW-1:0]    w_entry;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic             w_drop;
    logic [CW-1:0]    w_count_nxt;
    logic [AW-1:0]    w_rd_inc;
    logic [DW-1:0]    w_data_nxt;
    logic [CNT_W-1:0] w_fwd_inc;

    // FIFO control; a push into a full FIFO survives only if a pop frees a slot
    always_comb begin
        w_entry     = {PC, if_inst};
        w_push      = mon_en & ~stall;
        w_pop       = r_valid & trc.trc_ready;
        w_full      = (r_count == CW'(DEPTH));
        w_wr        = w_push & (~w_full | w_pop);
        w_drop      = w_push & w_full & ~w_pop;
        w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
        w_rd_inc    = r_rd_ptr + AW'(1);
        w_fwd_inc   = CNT_W'(FwdA != 2'b00) + CNT_W'(FwdB != 2'b00);
    end

    // Next head register value; holds the last head once the FIFO runs empty
    always_comb begin
        w_data_nxt = r_data;
        if (w_pop) begin
            if (r_count >= CW'(2)) begin
                w_data_nxt = r_mem[w_rd_inc];
            end else if (w_wr) begin
                w_data_nxt = w_entry;
            end
        end else if ((r_count == '0) && w_wr) begin
            w_data_nxt = w_entry;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge Clock) begin
        if (w_wr && !clr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_xfer_cnt  <= '0;
            r_fwd_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_xfer_cnt  <= '0;
            r_fwd_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_wr);
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
            r_count    <= w_count_nxt;
            r_valid    <= (w_count_nxt != '0);
            r_data     <= w_data_nxt;
            r_overflow <= r_overflow | w_drop;
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (mon_en) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                r_fwd_cnt   <= r_fwd_cnt + w_fwd_inc;
                if (stall) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end else if (pcsource != 2'b00) begin
                    r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign trc.trc_valid = r_valid;
    assign trc.trc_data  = r_data;
    assign overflow      = r_overflow;
    assign fifo_count    = r_count;
    assign cycle_cnt     = r_cycle_cnt;
    assign stall_cnt     = r_stall_cnt;
    assign xfer_cnt      = r_xfer_cnt;
    assign fwd_cnt       = r_fwd_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Directed bench for pipeline_trace_monitor: counters, FIFO order/wrap, overflow, clear and async reset.
module tb_pipeline_trace_monitor;

    logic        Clock;
    logic        Resetn;
    logic        mon_en;
    logic        clr;
    logic [31:0] PC;
    logic [1:0]  pcsource;
    logic [31:0] if_inst;
    logic        stall;
    logic [1:0]  FwdA;
    logic [1:0]  FwdB;
    logic        overflow;
    logic [4:0]  fifo_count;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] xfer_cnt;
    logic [31:0] fwd_cnt;
    logic [31:0] drop_cnt;

    int n_pass;
    int n_total;

    pipeline_trace_monitor_if trc_if();

    pipeline_trace_monitor #(.DEPTH(16), .CNT_W(32)) dut (
        .Clock(Clock), .Resetn(Resetn), .mon_en(mon_en), .clr(clr),
        .PC(PC), .pcsource(pcsource), .if_inst(if_inst), .stall(stall),
        .FwdA(FwdA), .FwdB(FwdB), .trc(trc_if),
        .overflow(overflow), .fifo_count(fifo_count),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt),
        .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        PC      = pc;
        if_inst = inst_of(pc);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; mon_en = 1'b0; clr = 1'b0; stall = 1'b0;
        pcsource = 2'b00; FwdA = 2'b00; FwdB = 2'b00; trc_if.trc_ready = 1'b0;
        set_pc(32'h0);
        #50;
        Resetn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_total++; if (cycle_cnt !== 32'd0) $display("FAIL reset_cycle_cnt got %0d exp 0", cycle_cnt); else n_pass++;
        n_total++; if ({stall_cnt, xfer_cnt, fwd_cnt, drop_cnt} !== 128'd0) $display("FAIL reset_counters got %0h exp 0", {stall_cnt, xfer_cnt, fwd_cnt, drop_cnt}); else n_pass++;
        n_total++; if (trc_if.trc_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", trc_if.trc_valid); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b exp 0", overflow); else n_pass++;
        n_total++; if (trc_if.trc_data !== 64'd0) $display("FAIL reset_data got %0h exp 0", trc_if.trc_data); else n_pass++;
        n_total++; if (fifo_count !== 5'd0) $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); else n_pass++;
    endtask

    task automatic test_stall();
        mon_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            stall = (i == 3) || (i == 4);
            set_pc(32'h100 + 32'(4 * i));
            tick();
        end
        mon_en = 1'b0; stall = 1'b0;
        n_total++; if (cycle_cnt !== 32'd8) $display("FAIL stall_cycle_cnt got %0d exp 8", cycle_cnt); else n_pass++;
        n_total++; if (stall_cnt !== 32'd2) $display("FAIL stall_stall_cnt got %0d exp 2", stall_cnt); else n_pass++;
        n_total++; if (xfer_cnt !== 32'd0) $display("FAIL stall_xfer_cnt got %0d exp 0", xfer_cnt); else n_pass++;
        n_total++; if (fifo_count !== 5'd6) $display("FAIL stall_fifo_count got %0d exp 6", fifo_count); else n_pass++;
        n_total++; if (trc_if.trc_data !== {32'h104, 32'hC0DE0104}) $display("FAIL stall_head got %0h exp %0h", trc_if.trc_data, {32'h104, 32'hC0DE0104}); else n_pass++;
    endtask

    task automatic test_fwd_branch();
        logic [1:0] fa [4];
        logic [1:0] fb [4];
        fa = '{2'b01, 2'b10, 2'b00, 2'b00};
        fb = '{2'b00, 2'b01, 2'b00, 2'b10};
        do_clear();
        n_total++; if (cycle_cnt !== 32'd0 || fifo_count !== 5'd0 || trc_if.trc_valid !== 1'b0) $display("FAIL clr_state got cyc=%0d cnt=%0d v=%0b exp 0/0/0", cycle_cnt, fifo_count, trc_if.trc_valid); else n_pass++;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            FwdA = fa[i]; FwdB = fb[i];
            pcsource = (i == 1) ? 2'b01 : 2'b00;
            set_pc(32'h200 + 32'(4 * i));
            tick();
            if (i == 0) begin
                n_total++; if (trc_if.trc_valid !== 1'b1) $display("FAIL push_latency_valid got %0b exp 1", trc_if.trc_valid); else n_pass++;
            end
            if (i == 1) begin
                n_total++; if (fwd_cnt !== 32'd3) $display("FAIL fwd_mid got %0d exp 3", fwd_cnt); else n_pass++;
            end
        end
        mon_en = 1'b0; FwdA = 2'b00; FwdB = 2'b00; pcsource = 2'b00;
        n_total++; if (fwd_cnt !== 32'd4) $display("FAIL fwd_cnt got %0d exp 4", fwd_cnt); else n_pass++;
        n_total++; if (xfer_cnt !== 32'd1) $display("FAIL xfer_cnt got %0d exp 1", xfer_cnt); else n_pass++;
        n_total++; if (cycle_cnt !== 32'd4) $display("FAIL fwd_cycle_cnt got %0d exp 4", cycle_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        do_clear();
        trc_if.trc_ready = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_pc(32'(4 * i));
            tick();
        end
        n_total++; if (fifo_count !== 5'd16) $display("FAIL wrap_full_count got %0d exp 16", fifo_count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL wrap_no_overflow got %0b exp 0", overflow); else n_pass++;
        trc_if.trc_ready = 1'b1;
        exp_pc = 32'h0;
        for (int k = 0; k < 24; k++) begin
            mon_en = (k < 8);
            set_pc(32'h40 + 32'(4 * k));
            n_total++;
            if (trc_if.trc_valid !== 1'b1 || trc_if.trc_data !== {exp_pc, inst_of(exp_pc)})
                $display("FAIL wrap_order[%0d] got v=%0b d=%0h exp v=1 d=%0h", k, trc_if.trc_valid, trc_if.trc_data, {exp_pc, inst_of(exp_pc)});
            else n_pass++;
            tick();
            exp_pc = exp_pc + 32'd4;
        end
        n_total++; if (trc_if.trc_valid !== 1'b0 || fifo_count !== 5'd0) $display("FAIL wrap_drained got v=%0b cnt=%0d exp 0/0", trc_if.trc_valid, fifo_count); else n_pass++;
        n_total++; if (trc_if.trc_data !== {32'h5C, 32'hC0DE005C}) $display("FAIL wrap_hold got %0h exp %0h", trc_if.trc_data, {32'h5C, 32'hC0DE005C}); else n_pass++;
        n_total++; if (drop_cnt !== 32'd0) $display("FAIL wrap_drop got %0d exp 0", drop_cnt); else n_pass++;
        tick();
        n_total++; if (fifo_count !== 5'd0 || trc_if.trc_data !== {32'h5C, 32'hC0DE005C}) $display("FAIL empty_pop got cnt=%0d d=%0h exp 0 and held data", fifo_count, trc_if.trc_data); else n_pass++;
    endtask

    task automatic test_overflow();
        do_clear();
        trc_if.trc_ready = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_pc(32'(4 * i));
            tick();
        end
        n_total++; if (fifo_count !== 5'd16) $display("FAIL ovf_count got %0d exp 16", fifo_count); else n_pass++;
        n_total++; if (drop_cnt !== 32'd4) $display("FAIL ovf_drop got %0d exp 4", drop_cnt); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", overflow); else n_pass++;
        n_total++; if (cycle_cnt !== 32'd20) $display("FAIL ovf_cycle_cnt got %0d exp 20", cycle_cnt); else n_pass++;
        trc_if.trc_ready = 1'b1;
        set_pc(32'h200);
        tick();
        n_total++; if (fifo_count !== 5'd16 || drop_cnt !== 32'd4) $display("FAIL full_push_pop got cnt=%0d drop=%0d exp 16/4", fifo_count, drop_cnt); else n_pass++;
        n_total++; if (trc_if.trc_data !== {32'h4, 32'hC0DE0004}) $display("FAIL full_head got %0h exp %0h", trc_if.trc_data, {32'h4, 32'hC0DE0004}); else n_pass++;
        mon_en = 1'b0;
        tick();
        n_total++; if (fifo_count !== 5'd15 || overflow !== 1'b1) $display("FAIL ovf_sticky got cnt=%0d ovf=%0b exp 15/1", fifo_count, overflow); else n_pass++;
        n_total++; if (trc_if.trc_data !== {32'h8, 32'hC0DE0008}) $display("FAIL drain_head got %0h exp %0h", trc_if.trc_data, {32'h8, 32'hC0DE0008}); else n_pass++;
    endtask

    task automatic test_clear_priority();
        mon_en = 1'b1; stall = 1'b0; pcsource = 2'b01; FwdA = 2'b01; FwdB = 2'b11;
        trc_if.trc_ready = 1'b1;
        set_pc(32'h250);
        clr = 1'b1;
        tick();
        clr = 1'b0; mon_en = 1'b0; pcsource = 2'b00; FwdA = 2'b00; FwdB = 2'b00;
        n_total++; if ({cycle_cnt, stall_cnt, xfer_cnt, fwd_cnt, drop_cnt} !== 160'd0) $display("FAIL clr_counters got %0h exp 0", {cycle_cnt, stall_cnt, xfer_cnt, fwd_cnt, drop_cnt}); else n_pass++;
        n_total++; if (fifo_count !== 5'd0 || trc_if.trc_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL clr_fifo got cnt=%0d v=%0b ovf=%0b exp 0/0/0", fifo_count, trc_if.trc_valid, overflow); else n_pass++;
        n_total++; if (trc_if.trc_data !== 64'd0) $display("FAIL clr_data got %0h exp 0", trc_if.trc_data); else n_pass++;
    endtask

    task automatic test_async_reset();
        trc_if.trc_ready = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'h300 + 32'(4 * i));
            tick();
        end
        n_total++; if (fifo_count !== 5'd3) $display("FAIL pre_reset_count got %0d exp 3", fifo_count); else n_pass++;
        #2 Resetn = 1'b0;
        #1;
        n_total++; if (fifo_count !== 5'd0 || trc_if.trc_valid !== 1'b0 || cycle_cnt !== 32'd0) $display("FAIL async_reset got cnt=%0d v=%0b cyc=%0d exp 0/0/0", fifo_count, trc_if.trc_valid, cycle_cnt); else n_pass++;
        n_total++; if (trc_if.trc_data !== 64'd0) $display("FAIL async_reset_data got %0h exp 0", trc_if.trc_data); else n_pass++;
        #1 Resetn = 1'b1;
        set_pc(32'h400);
        tick();
        mon_en = 1'b0;
        n_total++; if (fifo_count !== 5'd1 || cycle_cnt !== 32'd1) $display("FAIL post_reset_capture got cnt=%0d cyc=%0d exp 1/1", fifo_count, cycle_cnt); else n_pass++;
        n_total++; if (trc_if.trc_data !== {32'h400, 32'hC0DE0400}) $display("FAIL post_reset_head got %0h exp %0h", trc_if.trc_data, {32'h400, 32'hC0DE0400}); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_stall();
        test_fwd_branch();
        test_wrap();
        test_overflow();
        test_clear_priority();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
